uart_rx_fifo: RTL and testbench

- Receive-side buffer directly downstream of the UART receiver.
- Captures each byte the receiver reports with its one-cycle rx_end pulse and holds it in a DEPTH-entry circular FIFO until the CPU bus side pops it.
- Provides status (count/empty/full), a sticky overrun flag, a character-timeout detector and a level interrupt request.

---
 rtl/uart_rx_fifo.sv | 121 ++++++++++++
 tb/tb_uart_rx_fifo.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_fifo.sv
// Receive FIFO behind the UART receiver: circular byte buffer with status,
// sticky overrun, character-timeout detection and a level interrupt.
module uart_rx_fifo #(
  parameter int DEPTH     = 16,
  parameter int ADDR_W    = 4,
  parameter int IRQ_LEVEL = 8,
  parameter int TIMEOUT   = 2048
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rx_end,
  input  logic [7:0]        rx_data,
  input  logic              rx_busy,
  input  logic              rd_en,
  input  logic              flush,
  input  logic              ovr_clr,
  output logic [7:0]        rd_data,
  output logic              rd_valid,
  output logic [ADDR_W:0]   count,
  output logic              empty,
  output logic              full,
  output logic              overrun,
  output logic              timeout,
  output logic              irq
);

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W:0] IRQ_CNT  = (ADDR_W + 1)'(IRQ_LEVEL);
  localparam logic [TW-1:0]   TMAX     = TW'(TIMEOUT);

  logic [7:0]        mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic [TW-1:0]     tcnt;
  logic [TW-1:0]     tcnt_nxt;
  logic [ADDR_W:0]   count_nxt;
  logic              pop;
  logic              push;
  logic              ovr_evt;
  logic              overrun_nxt;
  logic              timeout_nxt;
  logic              irq_nxt;

  assign empty = (count == '0);
  assign full  = (count == FULL_CNT);

  always_comb begin
    pop     = rd_en & ~empty & ~flush;
    // A pop in the same cycle frees a slot, so a push into a full FIFO is accepted.
    push    = rx_end & (~full | pop) & ~flush;
    ovr_evt = rx_end & full & ~pop & ~flush;

    count_nxt = count;
    if (flush)
      count_nxt = '0;
    else if (push && !pop)
      count_nxt = count + (ADDR_W + 1)'(1);
    else if (pop && !push)
      count_nxt = count - (ADDR_W + 1)'(1);

    overrun_nxt = overrun;
    if (flush)
      overrun_nxt = 1'b0;
    else if (ovr_evt)
      overrun_nxt = 1'b1;
    else if (ovr_clr)
      overrun_nxt = 1'b0;

    tcnt_nxt = tcnt;
    if (flush || push || pop || rx_busy || empty)
      tcnt_nxt = '0;
    else if (tcnt != TMAX)
      tcnt_nxt = tcnt + TW'(1);

    if (flush || push || pop)
      timeout_nxt = 1'b0;
    else
      timeout_nxt = timeout | (tcnt_nxt == TMAX);

    irq_nxt = (count_nxt >= IRQ_CNT) | timeout_nxt | overrun_nxt;
  end

  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr] <= rx_data;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      rd_data  <= 8'h00;
      rd_valid <= 1'b0;
      overrun  <= 1'b0;
      timeout  <= 1'b0;
      tcnt     <= '0;
      irq      <= 1'b0;
    end else begin
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (push)
          wr_ptr <= wr_ptr + ADDR_W'(1);
        if (pop) begin
          rd_ptr  <= rd_ptr + ADDR_W'(1);
          rd_data <= mem[rd_ptr];
        end
      end
      rd_valid <= pop;
      count    <= count_nxt;
      overrun  <= overrun_nxt;
      timeout  <= timeout_nxt;
      tcnt     <= tcnt_nxt;
      irq      <= irq_nxt;
    end
  end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo: directed table, hand sequences and
// randomized traffic against a queue-based reference model.
module tb_uart_rx_fifo;

  localparam int DEPTH     = 16;
  localparam int ADDR_W    = 4;
  localparam int IRQ_LEVEL = 8;
  localparam int TIMEOUT   = 2048;

  logic              clk = 1'b0;
  logic              reset;
  logic              rx_end;
  logic [7:0]        rx_data;
  logic              rx_busy;
  logic              rd_en;
  logic              flush;
  logic              ovr_clr;
  logic [7:0]        rd_data;
  logic              rd_valid;
  logic [ADDR_W:0]   count;
  logic              empty;
  logic              full;
  logic              overrun;
  logic              timeout;
  logic              irq;

  always #5 clk = ~clk;

  uart_rx_fifo #(
    .DEPTH(DEPTH), .ADDR_W(ADDR_W), .IRQ_LEVEL(IRQ_LEVEL), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .reset(reset), .rx_end(rx_end), .rx_data(rx_data),
    .rx_busy(rx_busy), .rd_en(rd_en), .flush(flush), .ovr_clr(ovr_clr),
    .rd_data(rd_data), .rd_valid(rd_valid), .count(count), .empty(empty),
    .full(full), .overrun(overrun), .timeout(timeout), .irq(irq)
  );

  int checks = 0;
  int errors = 0;

  // reference model state
  logic [7:0] mq[$];
  bit         m_ovr, m_to, m_rdv, m_irq;
  logic [7:0] m_rdd;
  int         m_idle;

  typedef struct {
    bit         re;
    logic [7:0] d;
    bit         rd;
    bit         fl;
    int         exp_cnt;
    bit         exp_v;
    logic [7:0] exp_d;
  } vec_t;

  vec_t tbl[10];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_ovr = 0; m_to = 0; m_rdv = 0; m_irq = 0; m_rdd = 8'h00; m_idle = 0;
  endtask

  task automatic model_step();
    int  pre_size;
    bit  popped, pushed;
    pre_size = mq.size();
    if (flush) begin
      mq.delete();
      m_ovr = 0; m_to = 0; m_idle = 0; m_rdv = 0;
    end else begin
      popped = rd_en && (pre_size > 0);
      pushed = 0;
      m_rdv = popped;
      if (popped) m_rdd = mq.pop_front();
      if (ovr_clr) m_ovr = 0;
      if (rx_end) begin
        if (mq.size() < DEPTH) begin
          mq.push_back(rx_data);
          pushed = 1;
        end else begin
          m_ovr = 1;
        end
      end
      if (pushed || popped || rx_busy || pre_size == 0) m_idle = 0;
      else if (m_idle < TIMEOUT) m_idle++;
      if (pushed || popped) m_to = 0;
      else if (m_idle == TIMEOUT) m_to = 1;
    end
    m_irq = (mq.size() >= IRQ_LEVEL) || m_to || m_ovr;
  endtask

  task automatic compare_all();
    chk("count", int'(count), mq.size());
    chk("empty", int'(empty), int'(mq.size() == 0));
    chk("full", int'(full), int'(mq.size() == DEPTH));
    chk("overrun", int'(overrun), int'(m_ovr));
    chk("timeout", int'(timeout), int'(m_to));
    chk("irq", int'(irq), int'(m_irq));
    chk("rd_valid", int'(rd_valid), int'(m_rdv));
    chk("rd_data", int'(rd_data), int'(m_rdd));
  endtask

  task automatic drive(input bit re, input logic [7:0] d, input bit bz,
                       input bit rd, input bit fl, input bit oc);
    rx_end = re; rx_data = d; rx_busy = bz; rd_en = rd; flush = fl; ovr_clr = oc;
    @(posedge clk);
    model_step();
    #1;
    compare_all();
  endtask

  task automatic idle(input int n);
    repeat (n) drive(0, 8'h00, 0, 0, 0, 0);
  endtask

  task automatic do_flush();
    drive(0, 8'h00, 0, 0, 1, 0);
  endtask

  initial begin
    logic [7:0] last;
    int bias_re, bias_rd;

    reset = 1'b0;
    rx_end = 0; rx_data = 0; rx_busy = 0; rd_en = 0; flush = 0; ovr_clr = 0;
    model_reset();
    #23;
    chk("reset_count", int'(count), 0);
    chk("reset_empty", int'(empty), 1);
    chk("reset_irq", int'(irq), 0);
    chk("reset_rd_data", int'(rd_data), 0);
    reset = 1'b1;
    @(posedge clk); #1;
    compare_all();

    // fill and drain with spaced pushes
    for (int i = 0; i < 16; i++) begin
      drive(1, 8'(i), 0, 0, 0, 0);
      idle(9);
    end
    chk("fill_count", int'(count), 16);
    chk("fill_full", int'(full), 1);
    for (int i = 0; i < 16; i++) begin
      drive(0, 8'h00, 0, 1, 0, 0);
      chk("drain_valid", int'(rd_valid), 1);
      chk("drain_data", int'(rd_data), i);
    end
    chk("drain_empty", int'(empty), 1);
    chk("drain_count", int'(count), 0);

    // overrun
    for (int i = 0; i < 16; i++) drive(1, 8'(8'h10 + i), 0, 0, 0, 0);
    drive(1, 8'hAA, 0, 0, 0, 0);
    chk("ovr_flag", int'(overrun), 1);
    chk("ovr_count", int'(count), 16);
    chk("ovr_irq", int'(irq), 1);
    for (int i = 0; i < 16; i++) begin
      drive(0, 8'h00, 0, 1, 0, 0);
      chk("ovr_drain_data", int'(rd_data), 8'h10 + i);
    end
    drive(0, 8'h00, 0, 0, 0, 1);
    chk("ovr_clr", int'(overrun), 0);

    // full with simultaneous push and pop
    for (int i = 0; i < 16; i++) drive(1, 8'(8'h80 + i), 0, 0, 0, 0);
    drive(1, 8'h55, 0, 1, 0, 0);
    chk("fullsim_count", int'(count), 16);
    chk("fullsim_ovr", int'(overrun), 0);
    chk("fullsim_data", int'(rd_data), 8'h80);
    last = 8'h00;
    for (int i = 0; i < 16; i++) begin
      drive(0, 8'h00, 0, 1, 0, 0);
      last = rd_data;
    end
    chk("fullsim_last", int'(last), 8'h55);

    // empty with simultaneous push and pop
    drive(1, 8'h3C, 0, 1, 0, 0);
    chk("emptysim_valid", int'(rd_valid), 0);
    chk("emptysim_count", int'(count), 1);
    drive(0, 8'h00, 0, 1, 0, 0);
    chk("emptysim_data", int'(rd_data), 8'h3C);

    // threshold and timeout
    for (int i = 0; i < 7; i++) drive(1, 8'(8'h20 + i), 0, 0, 0, 0);
    idle(TIMEOUT - 1);
    chk("to_before", int'(timeout), 0);
    chk("to_before_irq", int'(irq), 0);
    idle(1);
    chk("to_set", int'(timeout), 1);
    chk("to_irq", int'(irq), 1);
    drive(0, 8'h00, 0, 1, 0, 0);
    chk("to_pop_clear", int'(timeout), 0);
    chk("to_pop_irq", int'(irq), 0);
    drive(1, 8'h30, 0, 0, 0, 0);
    drive(1, 8'h31, 0, 0, 0, 0);
    chk("lvl_count", int'(count), 8);
    chk("lvl_irq", int'(irq), 1);

    // rx_busy holds off timeout
    do_flush();
    for (int i = 0; i < 3; i++) drive(1, 8'(i), 0, 0, 0, 0);
    repeat (3000) drive(0, 8'h00, 1, 0, 0, 0);
    chk("busy_no_to", int'(timeout), 0);

    // flush with count=5, overrun=1, plus rx_end
    do_flush();
    for (int i = 0; i < 17; i++) drive(1, 8'(i), 0, 0, 0, 0);
    for (int i = 0; i < 11; i++) drive(0, 8'h00, 0, 1, 0, 0);
    chk("pre_flush_count", int'(count), 5);
    chk("pre_flush_ovr", int'(overrun), 1);
    drive(1, 8'h77, 0, 0, 1, 0);
    chk("flush_count", int'(count), 0);
    chk("flush_ovr", int'(overrun), 0);
    chk("flush_empty", int'(empty), 1);

    // reset mid-fill, checked before the next clock edge
    for (int i = 0; i < 4; i++) drive(1, 8'(i), 0, 0, 0, 0);
    drive(0, 8'h00, 0, 1, 0, 0);
    rx_end = 0; rd_en = 0;
    #2 reset = 1'b0;
    #1;
    model_reset();
    chk("arst_count", int'(count), 0);
    chk("arst_empty", int'(empty), 1);
    chk("arst_rd_data", int'(rd_data), 0);
    chk("arst_rd_valid", int'(rd_valid), 0);
    compare_all();
    #2 reset = 1'b1;

    // directed table from empty
    tbl[0] = '{1, 8'h11, 0, 0, 1, 0, 8'h00};
    tbl[1] = '{1, 8'h22, 0, 0, 2, 0, 8'h00};
    tbl[2] = '{1, 8'h33, 1, 0, 2, 1, 8'h11};
    tbl[3] = '{0, 8'h00, 1, 0, 1, 1, 8'h22};
    tbl[4] = '{0, 8'h00, 1, 0, 0, 1, 8'h33};
    tbl[5] = '{0, 8'h00, 1, 0, 0, 0, 8'h00};
    tbl[6] = '{1, 8'h44, 1, 0, 1, 0, 8'h00};
    tbl[7] = '{1, 8'h55, 0, 1, 0, 0, 8'h00};
    tbl[8] = '{1, 8'h66, 0, 0, 1, 0, 8'h00};
    tbl[9] = '{0, 8'h00, 1, 0, 0, 1, 8'h66};
    for (int i = 0; i < 10; i++) begin
      drive(tbl[i].re, tbl[i].d, 0, tbl[i].rd, tbl[i].fl, 0);
      chk("tbl_count", int'(count), tbl[i].exp_cnt);
      chk("tbl_valid", int'(rd_valid), int'(tbl[i].exp_v));
      if (tbl[i].exp_v) chk("tbl_data", int'(rd_data), int'(tbl[i].exp_d));
    end

    // randomized traffic with shifting fill/drain bias
    for (int seg = 0; seg < 15; seg++) begin
      bias_re = $urandom_range(20, 90);
      bias_rd = $urandom_range(20, 90);
      for (int c = 0; c < 200; c++) begin
        drive(($urandom_range(99) < bias_re), 8'($urandom),
              ($urandom_range(3) == 0), ($urandom_range(99) < bias_rd),
              ($urandom_range(63) == 0), ($urandom_range(15) == 0));
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
